// File: rtl/btb_update_ctrl_pkg.sv
// Shared BTB geometry, invalid-entry marker and controller state encoding.
// Imported by the BTB update controller and anything that reads the same table.
package btb_update_ctrl_pkg;

  localparam int unsigned BTB_WORD_SIZE  = 16;
  localparam int unsigned BTB_INDEX_BITS = 8;
  localparam int unsigned BTB_TAG_BITS   = BTB_WORD_SIZE - BTB_INDEX_BITS;
  localparam int unsigned BTB_FIFO_DEPTH = 4;

  localparam logic [BTB_WORD_SIZE-1:0] BTB_INVALID_TARGET = 16'hFFFF;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/btb_upd_fifo.sv
// Generic synchronous FIFO with flush; head entry is visible on head_dat_o while not empty.
// Push into a full FIFO and pop from an empty FIFO are ignored; flush wins over push/pop.
module btb_upd_fifo #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [DW-1:0]          push_dat_i,
  input  logic                   pop_i,
  output logic [DW-1:0]          head_dat_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int unsigned PW       = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o     = (count_q == FULL_CNT);
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign head_dat_o = mem_q[rd_ptr_q];
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_dat_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/btb_update_ctrl.sv
// BTB write sequencer: invalidation sweep after reset/invalidate, then in-order retire of resolve records.
// BTB write appears >=1 cycle after push and stalls on btb_wr_grant=0; res_ready drops while the buffer is full.
module btb_update_ctrl
  import btb_update_ctrl_pkg::*;
#(
  parameter int unsigned          WORD_SIZE      = BTB_WORD_SIZE,
  parameter int unsigned          INDEX_BITS     = BTB_INDEX_BITS,
  parameter int unsigned          TAG_BITS       = BTB_TAG_BITS,
  parameter int unsigned          FIFO_DEPTH     = BTB_FIFO_DEPTH,
  parameter logic [WORD_SIZE-1:0] INVALID_TARGET = BTB_INVALID_TARGET
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          res_valid,
  output logic                          res_ready,
  input  logic [WORD_SIZE-1:0]          res_pc,
  input  logic [WORD_SIZE-1:0]          res_target,
  input  logic                          res_taken,
  input  logic                          invalidate_req,
  output logic                          btb_wr_en,
  input  logic                          btb_wr_grant,
  output logic [INDEX_BITS-1:0]         btb_wr_index,
  output logic [TAG_BITS-1:0]           btb_wr_tag,
  output logic [WORD_SIZE-1:0]          btb_wr_target,
  output logic                          ctr_update,
  output logic                          ctr_taken,
  output logic                          pred_enable,
  output logic                          init_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  typedef struct packed {
    logic [WORD_SIZE-1:0] pc;
    logic [WORD_SIZE-1:0] target;
  } rec_t;

  localparam logic [INDEX_BITS-1:0] SWEEP_LAST = '1;

  state_e                state_q;
  state_e                state_d;
  logic [INDEX_BITS-1:0] sweep_q;
  logic [INDEX_BITS-1:0] sweep_d;
  logic                  armed_q;
  logic                  ctr_update_q;
  logic                  ctr_taken_q;

  rec_t push_rec;
  rec_t head_rec;
  logic fifo_full;
  logic fifo_empty;
  logic accept;
  logic push;
  logic pop;

  // armed_q keeps btb_wr_en low while reset is held and for the edge that releases it.
  assign res_ready     = (state_q == ST_RUN) && !fifo_full;
  assign pred_enable   = (state_q == ST_RUN);
  assign init_busy     = (state_q == ST_INIT);
  assign btb_wr_en     = (state_q == ST_INIT) ? armed_q : !fifo_empty;
  assign btb_wr_index  = (state_q == ST_INIT) ? sweep_q : head_rec.pc[INDEX_BITS-1:0];
  assign btb_wr_tag    = (state_q == ST_INIT) ? '0 : head_rec.pc[WORD_SIZE-1:INDEX_BITS];
  assign btb_wr_target = (state_q == ST_INIT) ? INVALID_TARGET : head_rec.target;
  assign ctr_update    = ctr_update_q;
  assign ctr_taken     = ctr_taken_q;

  assign push_rec = '{pc: res_pc, target: res_target};

  // The counter follows every accepted handshake; only the BTB record is dropped by invalidate.
  assign accept = res_valid && res_ready;
  assign push   = accept && !invalidate_req;
  assign pop    = (state_q == ST_RUN) && !fifo_empty && btb_wr_grant && !invalidate_req;

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    if (invalidate_req) begin
      state_d = ST_INIT;
      sweep_d = '0;
    end else if ((state_q == ST_INIT) && armed_q && btb_wr_grant) begin
      sweep_d = sweep_q + 1'b1;
      if (sweep_q == SWEEP_LAST) begin
        state_d = ST_RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_INIT;
      sweep_q      <= '0;
      armed_q      <= 1'b0;
      ctr_update_q <= 1'b0;
      ctr_taken_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sweep_q      <= sweep_d;
      armed_q      <= 1'b1;
      ctr_update_q <= accept;
      ctr_taken_q  <= accept && res_taken;
    end
  end

  btb_upd_fifo #(
    .DW    ($bits(rec_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush_i    (invalidate_req),
    .push_i     (push),
    .push_dat_i (push_rec),
    .pop_i      (pop),
    .head_dat_o (head_rec),
    .count_o    (fifo_count),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

endmodule
